detector_jogada_botoes: RTL and testbench
=========================================

// Module: detector_jogada_botoes
// PURPOSE
//   Conditions the four raw push-buttons before they reach the game datapath:
//   synchronises, debounces, rejects multi-button presses and emits exactly one
//   clean, latched one-hot play per physical press plus a 1-cycle pulse.
//   Sits directly upstream of the game top level; drives its botoes input.
// PARAMETERS
//   DEBOUNCE_CYCLES  5000  clock cycles a level must stay stable to be accepted (>=1)
//   CW               $clog2(DEBOUNCE_CYCLES+1)  stability counter width (derived)
// PORTS
//   clock        in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high
//   botoes_raw   in   4  raw buttons, asynchronous, active-high
//   habilita     in   1  accept new presses when 1
//   botoes       out  4  latched one-hot of last valid press (0 = none yet)
//   jogada       out  1  1-cycle pulse when botoes is updated
//   invalida     out  1  1-cycle pulse on stable multi-button press
//   db_estado    out  4  current FSM state code (debug, for hexa7seg)
// BEHAVIOUR
// - Reset (async, any time, incl. mid-debounce): FSM=OCIOSO, counter=0,
//   captured sample=0, sync regs=0; botoes=0, jogada=0, invalida=0, db_estado=0.
// - botoes_raw passes a 2-flop synchroniser -> sync[3:0]; FSM sees only sync.
// - States (db_estado code):
//   OCIOSO(0): wait. If habilita & sync!=0 -> ESTABILIZA, captura<=sync, cnt<=0.
//   ESTABILIZA(1): if sync!=captura or habilita=0 -> OCIOSO (glitch, no output).
//     else cnt++; when cnt==DEBOUNCE_CYCLES-1 -> PULSO if captura one-hot,
//     REJEITA otherwise (2+ bits set).
//   PULSO(2): botoes<=captura, jogada=1 this cycle only -> ESPERA_SOLTAR.
//   REJEITA(3): invalida=1 this cycle only; botoes unchanged -> ESPERA_SOLTAR.
//   ESPERA_SOLTAR(4): cnt counts while sync==0, cleared to 0 on any sync!=0;
//     when cnt==DEBOUNCE_CYCLES-1 with sync==0 -> OCIOSO, cnt<=0.
// - PULSO/REJEITA always complete once entered, regardless of habilita.
// - habilita=0 never blocks ESPERA_SOLTAR (release is always tracked).
// - jogada and invalida are Moore outputs, never both 1, never 2 cycles wide.
// - One physical press -> at most one jogada; holding a button never repeats.
// - Second button added while first held (during ESPERA_SOLTAR) is ignored.
// - botoes holds its value until the next PULSO; never cleared except by reset.
// - Latency: raw edge to jogada = 2 (sync) + 1 (OCIOSO) + DEBOUNCE_CYCLES + 1
//   cycles for a clean press (2+1+4+1=8 with DEBOUNCE_CYCLES=4).
// - Counter saturates logic-wise: compare with ==, never wraps past terminal.
// - Unused state codes 5..15 -> OCIOSO next cycle.
// TESTING (DEBOUNCE_CYCLES=4 for simulation)
// - Reset then idle: all outputs 0, db_estado=0 for 20 cycles.
// - Hold raw=4'b0100 for 12 cycles, habilita=1 -> exactly one jogada pulse
//   8 cycles after edge, botoes=4'b0100 thereafter; release -> db_estado back to 0.
// - Bounce: raw=0010 for 2 cycles, 0 for 1, 0010 for 2, then 0 -> no jogada,
//   botoes unchanged.
// - raw=1001 held 10 cycles -> one invalida pulse, jogada=0, botoes keeps old value.
// - habilita=0 with raw=0001 held 10 cycles -> no pulses; raise habilita while
//   still held -> one jogada after debounce.
// - Assert reset while in ESTABILIZA and while in ESPERA_SOLTAR -> immediate
//   botoes=0, db_estado=0, no pulse emitted after reset release.

Source files
------------

// File: rtl/detector_jogada_botoes.sv
// rtl/detector_jogada_botoes.sv - push-button conditioner: sync, debounce, multi-press reject, one play per press
module detector_jogada_botoes #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int CW = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_raw,
  input  logic       habilita,
  output logic [3:0] botoes,
  output logic       jogada,
  output logic       invalida,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    ESTABILIZA    = 4'd1,
    PULSO         = 4'd2,
    REJEITA       = 4'd3,
    ESPERA_SOLTAR = 4'd4
  } estado_t;

  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    captura_q, captura_d;
  logic [3:0]    botoes_d;
  logic [3:0]    sync_a, sync_b;
  logic          um_bit;

  // Two-flop synchroniser; only sync_b is seen by the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= 4'd0;
      sync_b <= 4'd0;
    end else begin
      sync_a <= botoes_raw;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      captura_q <= 4'd0;
      botoes    <= 4'd0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      captura_q <= captura_d;
      botoes    <= botoes_d;
    end
  end

  // Captured value is never zero in ESTABILIZA, so this identifies a single press.
  assign um_bit = (captura_q & (captura_q - 4'd1)) == 4'd0;

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    captura_d = captura_q;
    botoes_d  = botoes;
    jogada    = 1'b0;
    invalida  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (habilita && (sync_b != 4'd0)) begin
          estado_d  = ESTABILIZA;
          captura_d = sync_b;
          cnt_d     = '0;
        end
      end
      ESTABILIZA: begin
        if ((sync_b != captura_q) || !habilita) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = um_bit ? PULSO : REJEITA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PULSO: begin
        jogada   = 1'b1;
        botoes_d = captura_q;
        cnt_d    = '0;
        estado_d = ESPERA_SOLTAR;
      end
      REJEITA: begin
        invalida = 1'b1;
        cnt_d    = '0;
        estado_d = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        // Release is tracked even with habilita low so a held button never repeats.
        if (sync_b != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_FIM) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_detector_jogada_botoes.sv
// tb/tb_detector_jogada_botoes.sv - randomized and directed bench against a behavioural press model
module tb_detector_jogada_botoes;
  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes_raw;
  logic       habilita;
  logic [3:0] botoes;
  logic       jogada;
  logic       invalida;
  logic [3:0] db_estado;

  detector_jogada_botoes #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes_raw (botoes_raw),
    .habilita   (habilita),
    .botoes     (botoes),
    .jogada     (jogada),
    .invalida   (invalida),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_jog = 0;
  int n_inv = 0;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: phase 0 idle, 1 settling, 2 accepted, 3 rejected, 4 waiting for release.
  int         m_phase;
  int         m_run;
  logic [3:0] m_s1, m_s2, m_cap, m_botoes;

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_s1 = 0; m_s2 = 0; m_cap = 0; m_botoes = 0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    if (reset) begin
      model_reset();
      return;
    end
    s = m_s2;
    case (m_phase)
      0: if (habilita && s != 0) begin m_phase = 1; m_cap = s; m_run = 0; end
      1: begin
        if (s != m_cap || !habilita) m_phase = 0;
        else begin
          m_run++;
          if (m_run == DC) m_phase = ($countones(m_cap) == 1) ? 2 : 3;
        end
      end
      2: begin m_botoes = m_cap; m_phase = 4; m_run = 0; end
      3: begin m_phase = 4; m_run = 0; end
      default: begin
        if (s != 0) m_run = 0;
        else begin
          m_run++;
          if (m_run == DC) m_phase = 0;
        end
      end
    endcase
    m_s2 = m_s1;
    m_s1 = botoes_raw;
  endtask

  task automatic compare_all();
    check("botoes", 32'(botoes), 32'(m_botoes));
    check("jogada", 32'(jogada), 32'(m_phase == 2));
    check("invalida", 32'(invalida), 32'(m_phase == 3));
    check("db_estado", 32'(db_estado), 32'(m_phase));
  endtask

  // Called at a falling edge: check, count pulses, drive, step one clock.
  task automatic tick(input logic [3:0] raw, input logic hab);
    compare_all();
    if (jogada) n_jog++;
    if (invalida) n_inv++;
    botoes_raw = raw;
    habilita   = hab;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic ticks(input int n, input logic [3:0] raw, input logic hab);
    for (int i = 0; i < n; i++) tick(raw, hab);
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check({tag, "_botoes"}, 32'(botoes), 32'd0);
    check({tag, "_estado"}, 32'(db_estado), 32'd0);
    check({tag, "_pulse"}, 32'({jogada, invalida}), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; botoes_raw = 4'd0; habilita = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_botoes", 32'(botoes), 32'd0);
    check("reset_estado", 32'(db_estado), 32'd0);

    ticks(20, 4'd0, 1'b1);

    // Clean press: jogada in the 8th cycle after the raw edge.
    n_jog = 0; lat = -1;
    for (int k = 0; k < 12; k++) begin
      if (jogada && lat < 0) lat = k + 1;
      tick(4'b0100, 1'b1);
    end
    ticks(8, 4'd0, 1'b1);
    check("press_latency", 32'(lat), 32'd8);
    check("press_count", 32'(n_jog), 32'd1);
    check("press_botoes", 32'(botoes), 32'b0100);
    check("press_idle", 32'(db_estado), 32'd0);

    // Bounce never settles long enough.
    n_jog = 0;
    ticks(2, 4'b0010, 1'b1);
    ticks(1, 4'd0, 1'b1);
    ticks(2, 4'b0010, 1'b1);
    ticks(10, 4'd0, 1'b1);
    check("bounce_count", 32'(n_jog), 32'd0);
    check("bounce_botoes", 32'(botoes), 32'b0100);

    // Two buttons together: rejected.
    n_jog = 0; n_inv = 0;
    ticks(10, 4'b1001, 1'b1);
    ticks(8, 4'd0, 1'b1);
    check("multi_inv", 32'(n_inv), 32'd1);
    check("multi_jog", 32'(n_jog), 32'd0);
    check("multi_botoes", 32'(botoes), 32'b0100);

    // Disabled while held, then enabled with the button still down.
    n_jog = 0; n_inv = 0;
    ticks(10, 4'b0001, 1'b0);
    check("dis_pulses", 32'(n_jog + n_inv), 32'd0);
    ticks(10, 4'b0001, 1'b1);
    ticks(8, 4'd0, 1'b1);
    check("en_count", 32'(n_jog), 32'd1);
    check("en_botoes", 32'(botoes), 32'b0001);

    // Reset during debounce.
    n_jog = 0;
    ticks(4, 4'b1000, 1'b1);
    check("pre_rst_est", 32'(db_estado), 32'd1);
    async_reset_check("rst_est");
    botoes_raw = 4'd0;
    ticks(2, 4'd0, 1'b1);
    reset = 1'b0;
    ticks(10, 4'd0, 1'b1);
    check("rst_est_nojog", 32'(n_jog), 32'd0);

    // Reset while waiting for release.
    ticks(10, 4'b0010, 1'b1);
    check("pre_rst_wait", 32'(db_estado), 32'd4);
    n_jog = 0;
    async_reset_check("rst_wait");
    botoes_raw = 4'd0;
    ticks(2, 4'd0, 1'b1);
    reset = 1'b0;
    ticks(10, 4'd0, 1'b1);
    check("rst_wait_nojog", 32'(n_jog), 32'd0);
    check("rst_wait_botoes", 32'(botoes), 32'd0);

    // Randomized segments against the model.
    for (int seg = 0; seg < 400; seg++) begin
      int sel;
      logic [3:0] r;
      logic h;
      sel = $urandom_range(0, 99);
      if (sel < 55)      r = 4'(1 << $urandom_range(0, 3));
      else if (sel < 75) r = 4'd0;
      else               r = 4'($urandom_range(0, 15));
      h = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        async_reset_check("rand_rst");
        tick(r, h);
        reset = 1'b0;
      end
      ticks($urandom_range(1, 9), r, h);
    end
    compare_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
